// File: rtl/mdu_pipe_if.sv
// Handshake and data bundle between the E-stage controller and the MDU.
interface mdu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd;
    logic             done;

    modport master (
        output start, op, a, b, cancel,
        input  busy, stall_req, hi, lo, rd, done
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall_req, hi, lo, rd, done
    );
endinterface

// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no mult/div in flight; accepts ops, mthi/mtlo write HI/LO
//   S_RUN  | result latched, down-counter running; commits at zero
//
// The result is computed in the acceptance cycle and held until the
// counter expires, so operand changes after acceptance have no effect.
module mdu_pipe #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_pipe_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q, lo_q, res_hi_q, res_lo_q;
    logic             busy_q, done_q;

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   dvd, dvs, dvs_safe, uq, ur, q, r;
    logic [WIDTH-1:0]   res_hi_d, res_lo_d, rd_d;

    // Full-width products: sign- or zero-extend to 2*WIDTH and keep the low half.
    assign a_sx   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
    assign b_sx   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    assign a_zx   = {{WIDTH{1'b0}}, bus.a};
    assign b_zx   = {{WIDTH{1'b0}}, bus.b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed divide runs on magnitudes; the most-negative/-1 case falls out
    // naturally because its magnitude wraps back to the most-negative pattern.
    assign a_neg    = (bus.op == OP_DIV) & bus.a[WIDTH-1];
    assign b_neg    = (bus.op == OP_DIV) & bus.b[WIDTH-1];
    assign dvd      = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    assign dvs      = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
    assign dvs_safe = (dvs == '0) ? WIDTH'(1) : dvs;
    assign uq       = dvd / dvs_safe;
    assign ur       = dvd % dvs_safe;
    assign q        = (a_neg ^ b_neg) ? (~uq + WIDTH'(1)) : uq;
    assign r        = a_neg ? (~ur + WIDTH'(1)) : ur;

    // Select the HI/LO result for the op being presented this cycle.
    always_comb begin
        res_hi_d = '0;
        res_lo_d = '0;
        case (bus.op)
            OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
            OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (bus.b == '0) begin
                    res_hi_d = bus.a;
                    res_lo_d = '1;
                end else begin
                    res_hi_d = r;
                    res_lo_d = q;
                end
            end
            default: ;
        endcase
    end

    // Control FSM, down-counter and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                res_hi_q <= res_hi_d;
                                res_lo_q <= res_lo_d;
                                cnt      <= (bus.op[1]) ? DIV_LOAD : MULT_LOAD;
                                busy_q   <= 1'b1;
                                state    <= S_RUN;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (cnt == '0) begin
                        hi_q   <= res_hi_q;
                        lo_q   <= res_lo_q;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read port for mfhi/mflo; zero for every other op.
    always_comb begin
        rd_d = '0;
        if (bus.op == OP_MFHI)
            rd_d = hi_q;
        else if (bus.op == OP_MFLO)
            rd_d = lo_q;
    end

    // Every op value is an MDU op, so any start while busy must stall.
    assign bus.stall_req = bus.start & busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.rd        = rd_d;
endmodule

// File: tb/tb_mdu_pipe.sv
// Self-checking bench for mdu_pipe: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mdu_pipe;
    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mdu_pipe_if #(.WIDTH(W)) bus ();

    mdu_pipe #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of a mult/div, computed with 64-bit arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] va, vb,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint          sa = longint'($signed(va));
        longint          sb = longint'($signed(vb));
        longint unsigned ua = longint'(va);
        longint unsigned ub = longint'(vb);
        logic [63:0]     p;
        eh = '0;
        el = '0;
        case (o)
            3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            3'd1: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
            3'd2: begin
                if (vb == 0) begin eh = va; el = 32'hFFFF_FFFF; end
                else if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
                    eh = 32'h0; el = 32'h8000_0000;
                end else begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end
            end
            default: begin
                if (vb == 0) begin eh = va; el = 32'hFFFF_FFFF; end
                else begin
                    el = 32'(ua / ub);
                    eh = 32'(ua % ub);
                end
            end
        endcase
    endfunction

    // Issue a mult/div from idle and follow it to commit. If hold >= 0 the
    // controller presents that op (with a=ha) from the next cycle on, as a
    // stalled instruction waiting for busy to fall.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, vb,
                          input int hold, input logic [W-1:0] ha);
        logic [W-1:0] eh, el;
        int lat;
        model(o, va, vb, eh, el);
        lat = (o < 3'd2) ? ML : DL;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = va;
        bus.b     = vb;
        chk("stall_idle", bus.stall_req, 0);
        step();
        bus.b = $urandom;
        if (hold >= 0) begin
            bus.op = 3'(hold);
            bus.a  = ha;
        end else begin
            bus.start = 1'b0;
            bus.a     = $urandom;
        end
        for (int j = 0; j < lat; j++) begin
            chk("busy_run", bus.busy, 1);
            chk("done_early", bus.done, 0);
            chk("hi_hold", bus.hi, m_hi);
            chk("lo_hold", bus.lo, m_lo);
            if (hold >= 0) chk("stall_busy", bus.stall_req, 1);
            step();
        end
        chk("busy_end", bus.busy, 0);
        chk("done_pulse", bus.done, 1);
        chk("hi_res", bus.hi, eh);
        chk("lo_res", bus.lo, el);
        m_hi = eh;
        m_lo = el;
        if (hold >= 0) begin
            chk("stall_free", bus.stall_req, 0);
            if (hold == 4) chk("rd_mfhi", bus.rd, eh);
            if (hold == 5) chk("rd_mflo", bus.rd, el);
            if (hold == 6 || hold == 7) begin
                step();
                if (hold == 6) m_hi = ha; else m_lo = ha;
                chk("mt_after", bus.hi, m_hi);
                chk("mt_after_lo", bus.lo, m_lo);
            end
        end
        bus.start = 1'b0;
        step();
        chk("done_once", bus.done, 0);
    endtask

    initial begin
        logic [2:0]   o;
        logic [W-1:0] va, vb;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        repeat (3) step();
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b0;
        step();

        // Put a value in HI so the mid-operation reset has something to clear.
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'hABCD;
        step();
        bus.start = 1'b0;
        m_hi = 32'hABCD;
        chk("mthi_init", bus.hi, m_hi);

        // Reset two cycles into a MULT.
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 3; bus.b = 4;
        step();
        bus.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rstmid_hi", bus.hi, 0);
        chk("rstmid_lo", bus.lo, 0);
        chk("rstmid_busy", bus.busy, 0);
        step();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 8; i++) begin
            chk("rstmid_nodone", bus.done, 0);
            step();
        end
        chk("rstmid_hi2", bus.hi, 0);

        // rd is zero for non-move ops.
        bus.op = 3'd0;
        #1;
        chk("rd_zero", bus.rd, 0);

        // Directed arithmetic cases.
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, -1, 0);
        chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1, 0);
        chk("multu_hi_const", bus.hi, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 0);
        chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, -1, 0);
        chk("divu0_lo_const", bus.lo, 32'hFFFF_FFFF);
        chk("divu0_hi_const", bus.hi, 32'd7);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        chk("divovf_lo_const", bus.lo, 32'h8000_0000);
        chk("divovf_hi_const", bus.hi, 32'd0);
        run_op(3'd2, 32'd5, 32'd0, -1, 0);

        // Stalled MFLO, then stalled MTHI that lands once busy falls.
        run_op(3'd0, 32'd1234, 32'd5678, 5, 0);
        run_op(3'd2, 32'd99, 32'd7, 6, 32'h1234);
        chk("mthi_1234", bus.hi, 32'h1234);

        // Cancel in idle blocks an mtlo.
        bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'h5555; bus.cancel = 1'b1;
        step();
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("cancel_idle_lo", bus.lo, m_lo);

        // Cancel a DIVU 100/3 at cycle 4.
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 100; bus.b = 3;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("cancel_busy", bus.busy, 0);
        chk("cancel_done", bus.done, 0);
        for (int i = 0; i < 12; i++) begin
            chk("cancel_nodone", bus.done, 0);
            step();
        end
        chk("cancel_hi", bus.hi, m_hi);
        chk("cancel_lo", bus.lo, m_lo);
        run_op(3'd0, 32'd3, 32'd4, -1, 0);

        // Randomized mix of all ops.
        for (int n = 0; n < 60; n++) begin
            o  = 3'($urandom_range(0, 7));
            va = $urandom;
            vb = $urandom;
            case ($urandom_range(0, 7))
                0: vb = '0;
                1: vb = 32'hFFFF_FFFF;
                2: begin va = 32'h8000_0000; vb = 32'hFFFF_FFFF; end
                3: vb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            if (o < 3'd4) begin
                run_op(o, va, vb, -1, 0);
            end else if (o < 3'd6) begin
                bus.start = 1'b1; bus.op = o; bus.a = va;
                #1;
                chk("rd_rand", bus.rd, (o == 3'd4) ? m_hi : m_lo);
                step();
                bus.start = 1'b0;
                chk("mf_hi_keep", bus.hi, m_hi);
                chk("mf_lo_keep", bus.lo, m_lo);
            end else begin
                bus.start = 1'b1; bus.op = o; bus.a = va;
                step();
                bus.start = 1'b0;
                if (o == 3'd6) m_hi = va; else m_lo = va;
                chk("mt_hi_rand", bus.hi, m_hi);
                chk("mt_lo_rand", bus.lo, m_lo);
                chk("mt_busy", bus.busy, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers.
- Sits in the E stage of the 5-stage MIPS pipeline, beside the ALU. It takes forwarded operands and a decoded op from the E-stage controller.
- Runs multi-cycle mult/div with configurable latency and reports busy to the hazard unit. It serves mfhi/mflo reads and mthi/mtlo writes, and supports cancellation of an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >=8).
- MULT_LAT, 5, cycles from mult/multu acceptance to HI/LO update (>=1).
- DIV_LAT, 10, cycles from div/divu acceptance to HI/LO update (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  E-stage instruction is an MDU op, qualified by op.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- a  in  WIDTH  forwarded rs value.
- b  in  WIDTH  forwarded rt value.
- cancel  in  1  abort the in-flight mult/div (pipeline flush).
- busy  out  1  registered; high while an operation is in flight.
- stall_req  out  1  combinational; start & (op is any MDU op) & busy, OR start & op<4 & busy.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd  out  WIDTH  combinational; hi when op==MFHI, lo when op==MFLO, else 0.
- done  out  1  one-cycle pulse on the edge HI/LO are updated by mult/div.

Behaviour:
- Reset, asynchronous:
  - hi=lo=0, busy=0, done=0, counter=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE, start & op in {0..3}, cancel=0, at edge k:
  - Latch the op kind and compute/latch the result from a, b.
  - counter = LAT-1, where LAT = MULT_LAT or DIV_LAT; go to RUN; busy=1 after edge k.
- RUN:
  - Each edge, if counter==0: commit HI/LO, done=1 for one cycle, busy=0, go to IDLE.
  - Otherwise counter decrements.
  - Net effect: HI/LO are visible LAT cycles after the acceptance edge, and busy is high for exactly LAT cycles.
- LAT=1: busy is high one cycle; commit on edge k+1.
- start with any MDU op while busy: stall_req=1. The op is not accepted; a mthi/mtlo does not write and mfhi/mflo data must not be consumed. The controller holds the instruction until busy falls.
- MTHI/MTLO in IDLE with cancel=0: hi (or lo) <= a at that edge. busy is unaffected.
- MFHI/MFLO: rd is combinational from current hi/lo; no state change.
- cancel:
  - Highest priority after reset. In RUN it returns to IDLE next edge with busy=0, no commit, no done, and hi/lo unchanged.
  - In IDLE it blocks acceptance of start that cycle, including mthi/mtlo.
- Commit edge coinciding with start in IDLE is impossible: busy is still 1 that cycle, so stall_req blocks the start. The start is accepted on the following edge.
- MULT: signed full product {hi,lo} = a*b (2*WIDTH bits).
- MULTU: unsigned full product {hi,lo} = a*b.
- DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of a.
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero, DIV and DIVU: lo = all ones, hi = a.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- Operands are sampled only at the acceptance edge. Later changes to a/b have no effect.

Test Plan:
- Reset mid-operation: start MULT a=3, b=4, reset asserted 2 cycles later -> immediately hi=lo=0, busy=0; no done pulse afterward.
- MULT a=0xFFFFFFFF (-1), b=2, MULT_LAT=5 -> busy high 5 cycles; hi=0xFFFFFFFF and lo=0xFFFFFFFE at edge k+5; done one pulse. MULTU with same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue MFLO one cycle after MULT start -> stall_req=1 for the remaining busy cycles. After busy falls, stall_req=0 and rd equals the new lo.
- MTHI a=0x1234 while busy -> stall_req=1, hi unchanged. Repeat in IDLE -> hi=0x1234 next edge.
- DIVU 100/3 started, cancel pulsed at cycle 4 -> busy=0 next edge, no done, hi/lo retain prior values. New MULT accepted on the following start.
